// File: rtl/siso_shift_ctrl_pkg.sv
// Shared state encoding and counter sizing for the SISO shift-register sequencer.
package siso_shift_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, FLUSH, DONE, ABORT} state_t;

  // Sized for the longest reload value so the down-counter never wraps.
  function automatic int cnt_w(input int width, input int depth);
    int m;
    m = (width > depth) ? width : depth;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/siso_shift_ctrl_cnt.sv
// Loadable down-counter with zero flag, shared by the SHIFT/FLUSH phases and the bit_valid window.
module siso_shift_ctrl_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [CW-1:0] o_count_nxt,
  output logic          o_zero
);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  // Decrement saturates at zero; a reload always takes priority.
  always_comb begin
    w_count_nxt = r_count;
    if (i_load) begin
      w_count_nxt = i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count_nxt = w_count_nxt;
  assign o_zero      = (r_count == '0);

endmodule

// File: rtl/siso_shift_ctrl.sv
// Sequencer feeding a DEPTH-stage SISO shift register from a valid/ready word source.
// Optional even-parity trailer bit and parity_bit port enabled by SISO_SHIFT_CTRL_PARITY_EN.
module siso_shift_ctrl
  import siso_shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             abort,
  output logic             sr_clr,
  output logic             sr_en,
  output logic             sr_in,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted
`ifdef SISO_SHIFT_CTRL_PARITY_EN
  ,
  output logic             parity_bit
`endif
);

`ifdef SISO_SHIFT_CTRL_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int            CW         = cnt_w(N, DEPTH);
  localparam logic [CW-1:0] SHIFT_LOAD = CW'(N - 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(DEPTH - 2);

  state_t        r_state;
  state_t        w_nxt_state;
  logic [N-1:0]  r_seq;
  logic [N-1:0]  w_seq;
  logic          w_accept;
  logic          w_cnt_load;
  logic [CW-1:0] w_cnt_load_val;
  logic          w_cnt_dec;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_cnt_zero;
  logic          w_sr_in_nxt;
  logic          w_bit_valid_nxt;
  logic          r_s_ready, r_sr_clr, r_sr_en, r_sr_in, r_bit_valid;
  logic          r_busy, r_done, r_aborted;

  assign w_accept = (r_state == IDLE) && s_valid;

  // Word is stored in transmit order indexed by the counter: r_seq[N-1] goes out first.
  always_comb begin
    w_seq = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_seq[N-1-i] = (MSB_FIRST != 0) ? s_data[WIDTH-1-i] : s_data[i];
    end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    w_seq[0] = ^s_data;
`endif
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid) begin
          w_nxt_state = CLEAR;
          w_cnt_load  = 1'b1;
        end
      end
      CLEAR: begin
        w_cnt_load = 1'b1;
        if (abort) begin
          w_nxt_state = ABORT;
        end else begin
          w_nxt_state    = SHIFT;
          w_cnt_load_val = SHIFT_LOAD;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_nxt_state = ABORT;
          w_cnt_load  = 1'b1;
        end else if (w_cnt_zero) begin
          w_nxt_state    = FLUSH;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = FLUSH_LOAD;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      FLUSH: begin
        if (abort) begin
          w_nxt_state = ABORT;
          w_cnt_load  = 1'b1;
        end else if (w_cnt_zero) begin
          w_nxt_state = DONE;
          w_cnt_load  = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_cnt_load  = 1'b1;
      end
    endcase
  end

  siso_shift_ctrl_cnt #(.CW(CW)) u_cnt (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_cnt_load),
    .i_load_val  (w_cnt_load_val),
    .i_dec       (w_cnt_dec),
    .o_count_nxt (w_cnt_nxt),
    .o_zero      (w_cnt_zero)
  );

  // bit_valid covers the last N cycles up to and including DONE, i.e. remaining-cycles < N.
  always_comb begin
    w_sr_in_nxt     = 1'b0;
    w_bit_valid_nxt = 1'b0;
    if (w_nxt_state == SHIFT) begin
      for (int i = 0; i < N; i++) begin
        if (w_cnt_nxt == CW'(i)) w_sr_in_nxt = r_seq[i];
      end
    end
    case (w_nxt_state)
      SHIFT:   w_bit_valid_nxt = (int'(w_cnt_nxt) + DEPTH <= N - 1);
      FLUSH:   w_bit_valid_nxt = (int'(w_cnt_nxt) + 2 <= N);
      DONE:    w_bit_valid_nxt = 1'b1;
      default: w_bit_valid_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_seq       <= '0;
      r_s_ready   <= 1'b1;
      r_sr_clr    <= 1'b0;
      r_sr_en     <= 1'b0;
      r_sr_in     <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      if (w_accept) r_seq <= w_seq;
      r_s_ready   <= (w_nxt_state == IDLE);
      r_sr_clr    <= (w_nxt_state == CLEAR) || (w_nxt_state == ABORT);
      r_sr_en     <= (w_nxt_state == SHIFT) || (w_nxt_state == FLUSH);
      r_sr_in     <= w_sr_in_nxt;
      r_bit_valid <= w_bit_valid_nxt;
      r_busy      <= (w_nxt_state != IDLE);
      r_done      <= (w_nxt_state == DONE);
      r_aborted   <= (w_nxt_state == ABORT);
    end
  end

`ifdef SISO_SHIFT_CTRL_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^s_data;
    end
  end

  assign parity_bit = r_parity;
`endif

  assign s_ready   = r_s_ready;
  assign sr_clr    = r_sr_clr;
  assign sr_en     = r_sr_en;
  assign sr_in     = r_sr_in;
  assign bit_valid = r_bit_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: LSB-first and MSB-first instances checked every cycle against a timeline model,
// plus a shift-register model on each output; build with SISO_SHIFT_CTRL_PARITY_EN for the parity variant.
`timescale 1ns/1ps
module tb_siso_shift_ctrl;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int LAST = N + DEPTH + 1;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic             sValid = 1'b0;
  logic [WIDTH-1:0] sData = '0;
  logic             abortIn = 1'b0;
  logic [1:0]       sReady, srClr, srEn, srIn, bitValid, busy, done, aborted;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
  logic [1:0]       parityBit;
`endif
  logic [DEPTH-1:0] qLsb, qMsb;
  int               checks = 0;
  int               failures = 0;
  int               cycleCount = 0;
  int               doneStamps[$];

  always #5 clk = ~clk;

  siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0)) dutLsb (
    .clk(clk), .reset_n(resetN), .s_valid(sValid), .s_ready(sReady[0]), .s_data(sData),
    .abort(abortIn), .sr_clr(srClr[0]), .sr_en(srEn[0]), .sr_in(srIn[0]),
    .bit_valid(bitValid[0]), .busy(busy[0]), .done(done[0]), .aborted(aborted[0])
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    , .parity_bit(parityBit[0])
`endif
  );

  siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) dutMsb (
    .clk(clk), .reset_n(resetN), .s_valid(sValid), .s_ready(sReady[1]), .s_data(sData),
    .abort(abortIn), .sr_clr(srClr[1]), .sr_en(srEn[1]), .sr_in(srIn[1]),
    .bit_valid(bitValid[1]), .busy(busy[1]), .done(done[1]), .aborted(aborted[1])
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    , .parity_bit(parityBit[1])
`endif
  );

  // Controlled datapath: q[DEPTH-1] takes sr_in, q[0] is the serial output.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) qLsb <= '0;
    else if (srClr[0]) qLsb <= '0;
    else if (srEn[0]) qLsb <= {srIn[0], qLsb[DEPTH-1:1]};
  end

  always @(posedge clk or negedge resetN) begin
    if (!resetN) qMsb <= '0;
    else if (srClr[1]) qMsb <= '0;
    else if (srEn[1]) qMsb <= {srIn[1], qMsb[DEPTH-1:1]};
  end

  always @(posedge clk) begin
    if (done[0]) doneStamps.push_back(cycleCount);
    cycleCount++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // j-th bit sent on the wire, parity appended after the data when enabled.
  function automatic logic [N-1:0] buildSeq(input logic [WIDTH-1:0] w, input bit msb);
    logic [N-1:0] s;
    s = '0;
    for (int j = 0; j < WIDTH; j++) s[j] = msb ? w[WIDTH-1-j] : w[j];
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    s[WIDTH] = ^w;
`endif
    return s;
  endfunction

  // Expected {rdy,busy,clr,en,in,bv,done,abt} in cycle Ck after accept; eff = cycle abort was seen (0 = none).
  function automatic logic [7:0] expectOut(input int k, input int eff, input logic [N-1:0] s);
    logic rdy, bsy, clr, en, din, bv, dn, ab;
    {rdy, bsy, clr, en, din, bv, dn, ab} = 8'h00;
    if (eff > 0 && k == eff + 1) begin
      bsy = 1'b1; clr = 1'b1; ab = 1'b1;
    end else if ((eff > 0 && k > eff + 1) || k > LAST) begin
      rdy = 1'b1;
    end else begin
      bsy = 1'b1;
      if (k == 1) clr = 1'b1;
      else if (k <= N + 1) begin en = 1'b1; din = s[k-2]; end
      else if (k <= N + DEPTH) en = 1'b1;
      else dn = 1'b1;
      bv = (k >= DEPTH + 2) && (k <= DEPTH + N + 1);
    end
    return {rdy, bsy, clr, en, din, bv, dn, ab};
  endfunction

  function automatic logic [7:0] obsVec(input int d);
    return {sReady[d], busy[d], srClr[d], srEn[d], srIn[d], bitValid[d], done[d], aborted[d]};
  endfunction

  task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int k, input int eff, input logic [WIDTH-1:0] word);
    logic [N-1:0] sL, sM;
    logic [7:0]   eL, eM;
    sL = buildSeq(word, 1'b0);
    sM = buildSeq(word, 1'b1);
    eL = expectOut(k, eff, sL);
    eM = expectOut(k, eff, sM);
    compare($sformatf("lsb C%0d {rdy,busy,clr,en,in,bv,done,abt}", k), obsVec(0), eL);
    compare($sformatf("msb C%0d {rdy,busy,clr,en,in,bv,done,abt}", k), obsVec(1), eM);
    if (eL[2]) begin
      compare($sformatf("lsb q_out C%0d", k), {7'd0, qLsb[0]}, {7'd0, sL[k-DEPTH-2]});
      compare($sformatf("msb q_out C%0d", k), {7'd0, qMsb[0]}, {7'd0, sM[k-DEPTH-2]});
    end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    compare($sformatf("parity C%0d", k), {6'd0, parityBit}, {6'd0, {2{^word}}});
`endif
  endtask

  task automatic checkReset(input string tag);
    compare({"lsb ", tag}, obsVec(0), 8'b1000_0000);
    compare({"msb ", tag}, obsVec(1), 8'b1000_0000);
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    compare({"parity ", tag}, {6'd0, parityBit}, 8'd0);
`endif
  endtask

  // Presents a word for one edge; leaves the bench in C1 of the accepted transfer.
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input bit withAbort);
    sValid  = 1'b1;
    sData   = word;
    abortIn = withAbort;
    step();
    abortIn = 1'b0;
    sValid  = 1'b0;
  endtask

  // Walks a transfer from C1 to its first IDLE cycle; with chain, s_valid stays high and the next word is accepted.
  task automatic runTransfer(input logic [WIDTH-1:0] word, input int abortAt, input bit chain,
                             input logic [WIDTH-1:0] nextWord);
    int eff, endK;
    eff  = (abortAt >= 1 && abortAt <= N + DEPTH) ? abortAt : 0;
    endK = (eff > 0) ? eff + 2 : LAST + 1;
    for (int k = 1; k <= endK; k++) begin
      checkOutput(k, eff, word);
      if (k == endK && !chain) begin
        abortIn = 1'b0;
        sValid  = 1'b0;
      end else begin
        abortIn = (k == abortAt);
        sValid  = chain;
        sData   = chain ? nextWord : WIDTH'($urandom);
        step();
      end
    end
    abortIn = 1'b0;
    sValid  = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] w, nw;
    bit               ch;
    int               ab, gap, diff;

    $display("[TB] reset state");
    step();
    checkReset("reset");
    resetN = 1'b1;
    step();
    checkReset("after release");

    $display("[TB] basic 1011 (lsb and msb instances)");
    applyStimulus(4'b1011, 1'b0);
    runTransfer(4'b1011, 0, 1'b0, '0);

    $display("[TB] abort in C4, then 0110");
    applyStimulus(4'b1110, 1'b0);
    runTransfer(4'b1110, 4, 1'b0, '0);
    applyStimulus(4'b0110, 1'b0);
    runTransfer(4'b0110, 0, 1'b0, '0);

    $display("[TB] back-to-back 1011 then 0001");
    doneStamps.delete();
    applyStimulus(4'b1011, 1'b0);
    runTransfer(4'b1011, 0, 1'b1, 4'b0001);
    runTransfer(4'b0001, 0, 1'b0, '0);
    diff = (doneStamps.size() >= 2) ? doneStamps[1] - doneStamps[0] : -1;
    compare("b2b done pulses", 8'(doneStamps.size()), 8'd2);
    compare("b2b done spacing", 8'(diff), 8'(N + DEPTH + 2));

    $display("[TB] abort ignored in DONE, abort with s_valid in IDLE");
    applyStimulus(4'b1001, 1'b0);
    runTransfer(4'b1001, LAST, 1'b0, '0);
    applyStimulus(4'b0111, 1'b1);
    runTransfer(4'b0111, 1, 1'b0, '0);

    $display("[TB] reset mid-SHIFT");
    applyStimulus(4'b1101, 1'b0);
    repeat (3) step();
    #2 resetN = 1'b0;
    #1 checkReset("async reset mid-shift");
    step();
    #2 resetN = 1'b1;
    for (int i = 0; i < LAST + 2; i++) begin
      step();
      checkReset($sformatf("idle after reset +%0d", i));
    end

    $display("[TB] randomized transfers");
    w = WIDTH'($urandom);
    applyStimulus(w, 1'b0);
    for (int it = 0; it < 24; it++) begin
      nw = WIDTH'($urandom);
      ch = ($urandom_range(0, 1) == 1) && (it != 23);
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAST)) : 0;
      runTransfer(w, ab, ch, nw);
      if (!ch && it != 23) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          step();
          checkOutput(LAST + 1, 0, w);
        end
        applyStimulus(nw, 1'b0);
      end
      w = nw;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
